fifo_stream_reader: RTL and testbench

- Drain-side controller for the team's synchronous FIFO.
- Issues pops to the FIFO read port, absorbing its one-cycle registered read latency.
- Presents popped words on a valid/ready stream with a 3-entry skid buffer.
- Tags every BURST_LEN-th word with a last flag so downstream logic sees fixed-length bursts.

---
 rtl/fifo_stream_reader_if.sv | 31 +++
 rtl/fifo_stream_reader.sv | 101 ++++++++++
 tb/tb_fifo_stream_reader.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_reader_if
// Brief    : FIFO read-port and valid/ready stream bundle for fifo_stream_reader.
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_stream_reader_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  en;
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_dout;
   logic                  fifo_rd_en;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_valid;
   logic                  m_ready;
   logic                  m_last;
   logic                  idle;

   // The reader drives the pop request and the stream.
   modport master (
      input  en, fifo_empty, fifo_dout, m_ready,
      output fifo_rd_en, m_data, m_valid, m_last, idle
   );

   modport slave (
      output en, fifo_empty, fifo_dout, m_ready,
      input  fifo_rd_en, m_data, m_valid, m_last, idle
   );
endinterface
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_reader
// Brief    : Pops a registered-output FIFO into a 3-deep skid buffer and
//            presents the words as a valid/ready stream tagged in bursts.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_stream_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int BURST_LEN  = 4,
   parameter int CNT_WIDTH  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
   input  wire logic             clk,
   input  wire logic             rst,
   fifo_stream_reader_if.master  bus
);

   localparam logic [CNT_WIDTH-1:0] c_LAST_BEAT = CNT_WIDTH'(BURST_LEN - 1);

   logic [1:0]            r_count;
   logic [1:0]            r_wr_idx;
   logic [1:0]            r_rd_idx;
   logic                  r_inflight;
   logic [CNT_WIDTH-1:0]  r_beat_cnt;
   logic [DATA_WIDTH-1:0] r_mem [0:2];

   logic [2:0]            w_outstanding;
   logic                  w_rd_en;
   logic                  w_valid;
   logic                  w_hs;
   logic                  w_push;
   logic                  w_last_beat;
   logic [DATA_WIDTH-1:0] w_head;

   function automatic logic [1:0] f_next_idx(input logic [1:0] i_idx);
      return (i_idx == 2'd2) ? 2'd0 : i_idx + 2'd1;
   endfunction

   // Words popped but not yet retired; capped so a late capture always has a slot.
   assign w_outstanding = {1'b0, r_count} + {2'b00, r_inflight};
   assign w_rd_en       = !rst && bus.en && !bus.fifo_empty && (w_outstanding <= 3'd2);
   assign w_valid       = (r_count != 2'd0);
   assign w_hs          = w_valid && bus.m_ready;
   assign w_push        = r_inflight;
   assign w_last_beat   = (r_beat_cnt == c_LAST_BEAT);

   always_comb begin
      w_head = r_mem[2];
      case (r_rd_idx)
         2'd0:    w_head = r_mem[0];
         2'd1:    w_head = r_mem[1];
         default: w_head = r_mem[2];
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count    <= 2'd0;
         r_wr_idx   <= 2'd0;
         r_rd_idx   <= 2'd0;
         r_inflight <= 1'b0;
         r_beat_cnt <= '0;
      end else begin
         r_inflight <= w_rd_en;
         if (w_push) begin
            r_wr_idx <= f_next_idx(r_wr_idx);
         end
         if (w_hs) begin
            r_rd_idx   <= f_next_idx(r_rd_idx);
            r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + 1'b1;
         end
         case ({w_push, w_hs})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (!rst && w_push) begin
         for (int i = 0; i < 3; i++) begin
            if (r_wr_idx == 2'(i)) begin
               r_mem[i] <= bus.fifo_dout;
            end
         end
      end
   end

   assign bus.fifo_rd_en = w_rd_en;
   assign bus.m_valid    = w_valid;
   assign bus.m_data     = w_valid ? w_head : '0;
   assign bus.m_last     = w_valid && w_last_beat;
   assign bus.idle       = (r_count == 2'd0) && !r_inflight;

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(w_push && !w_hs && (r_count == 2'd3)));

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_stream_reader
// Brief    : Directed bench with a queue-based model of the reader and FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_reader;

   localparam int DW = 8;
   localparam int BL = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

   fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // FIFO with a registered read port
   logic [DW-1:0] fmem [0:255];
   int            fhead = 0;
   int            ftail = 0;
   logic [DW-1:0] fdout = '0;

   assign bus.fifo_empty = (fhead == ftail);
   assign bus.fifo_dout  = fdout;

   always @(posedge clk) begin
      if (bus.fifo_rd_en && (fhead != ftail)) begin
         fdout <= fmem[fhead];
         fhead <= fhead + 1;
      end
   end

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: every word popped is owed to the stream; visible two cycles after its pop.
   typedef struct {
      logic [DW-1:0] d;
      int            rdy;
   } ent_t;
   ent_t mq[$];
   int   cyc   = 0;
   int   beats = 0;
   bit   chk_en = 1'b0;

   logic [DW-1:0] log_d[$];
   logic          log_l[$];
   int pops = 0;
   int pops_en_low = 0;
   int hs_en_low = 0;
   int first_rd = -1;
   int first_v = -1;

   always @(negedge clk) begin : p_chk
      logic          e_rd;
      logic          e_v;
      logic          e_l;
      logic          e_idle;
      logic [DW-1:0] e_d;
      e_v = 1'b0;
      e_d = '0;
      if (mq.size() > 0) begin
         if (mq[0].rdy <= cyc) begin
            e_v = 1'b1;
            e_d = mq[0].d;
         end
      end
      e_l    = e_v && ((beats % BL) == BL - 1);
      e_idle = (mq.size() == 0);
      e_rd   = !rst && bus.en && (fhead != ftail) && (mq.size() <= 2);
      if (chk_en) begin
         check("rd_en",   32'(bus.fifo_rd_en), 32'(e_rd));
         check("m_valid", 32'(bus.m_valid),    32'(e_v));
         check("m_data",  32'(bus.m_data),     32'(e_d));
         check("m_last",  32'(bus.m_last),     32'(e_l));
         check("idle",    32'(bus.idle),       32'(e_idle));
      end
      if (!rst) begin
         if (bus.m_valid && bus.m_ready) begin
            log_d.push_back(bus.m_data);
            log_l.push_back(bus.m_last);
            if (!bus.en) hs_en_low++;
         end
         if (bus.fifo_rd_en) begin
            pops++;
            if (!bus.en) pops_en_low++;
            if (first_rd < 0) first_rd = cyc;
         end
         if (bus.m_valid && first_v < 0) first_v = cyc;
      end
      if (rst) begin
         mq.delete();
         beats = 0;
      end else begin
         if (e_v && bus.m_ready) begin
            void'(mq.pop_front());
            beats++;
         end
         if (e_rd) mq.push_back(ent_t'{fmem[fhead], cyc + 2});
      end
      cyc++;
   end

   task automatic load(input int base, input int n);
      for (int i = 0; i < n; i++) begin
         fmem[ftail] = DW'(base + i);
         ftail = ftail + 1;
      end
   endtask

   task automatic clear_logs();
      log_d.delete();
      log_l.delete();
      pops = 0;
      pops_en_low = 0;
      hs_en_low = 0;
      first_rd = -1;
      first_v = -1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      ftail = fhead;
      @(posedge clk);
      #1 rst = 1'b0;
      clear_logs();
   endtask

   task automatic wait_beats(input int n, input int budget, input string name);
      int k = 0;
      while (log_d.size() < n && k < budget) begin
         @(posedge clk);
         k++;
      end
      #1;
      check(name, 32'(log_d.size() >= n), 32'd1);
   endtask

   task automatic check_seq(input string name, input int base, input int n);
      for (int i = 0; i < n && i < log_d.size(); i++) begin
         check({name, "_data"}, 32'(log_d[i]), 32'(base + i));
         check({name, "_last"}, 32'(log_l[i]), 32'((i % BL) == BL - 1));
      end
   endtask

   initial begin
      bus.en      = 1'b1;
      bus.m_ready = 1'b0;
      load(8'h10, 8);

      // Reset held two cycles with data waiting
      @(posedge clk);
      #1 chk_en = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("rst_valid", 32'(bus.m_valid),    32'd0);
         check("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
         check("rst_idle",  32'(bus.idle),       32'd1);
         check("rst_data",  32'(bus.m_data),     32'd0);
      end

      // Full-rate drain
      @(posedge clk);
      #1 bus.m_ready = 1'b1;
      clear_logs();
      rst = 1'b0;
      wait_beats(8, 40, "drain_timeout");
      repeat (3) @(posedge clk);
      #1;
      check_seq("drain", 8'h10, 8);
      check("drain_latency", 32'(first_v - first_rd), 32'd2);
      check("drain_pops", 32'(pops), 32'd8);
      check("drain_idle", 32'(bus.idle), 32'd1);
      check("drain_rd_en", 32'(bus.fifo_rd_en), 32'd0);

      // Backpressure
      bus.m_ready = 1'b0;
      do_reset();
      load(8'h10, 8);
      repeat (10) begin
         @(negedge clk);
         if (bus.m_valid) check("stall_data", 32'(bus.m_data), 32'h10);
      end
      check("stall_pops", 32'(pops), 32'd3);
      check("stall_rd_en", 32'(bus.fifo_rd_en), 32'd0);
      @(posedge clk);
      #1 bus.m_ready = 1'b1;
      wait_beats(8, 40, "bp_timeout");
      repeat (3) @(posedge clk);
      check_seq("bp", 8'h10, 8);
      check("bp_count", 32'(log_d.size()), 32'd8);

      // Empty source
      do_reset();
      repeat (20) begin
         @(negedge clk);
         check("empty_rd_en", 32'(bus.fifo_rd_en), 32'd0);
         check("empty_idle",  32'(bus.idle),       32'd1);
      end
      check("empty_pops", 32'(pops), 32'd0);

      // Enable gap after two accepted beats
      do_reset();
      load(8'h10, 8);
      wait_beats(2, 20, "gap_timeout");
      bus.en = 1'b0;
      repeat (5) @(posedge clk);
      #1 bus.en = 1'b1;
      wait_beats(8, 40, "gap_resume_timeout");
      check("gap_pops_low", 32'(pops_en_low), 32'd0);
      check("gap_drain_le2", 32'(hs_en_low <= 2), 32'd1);
      check_seq("gap", 8'h10, 8);

      // Reset with two buffered words and one in flight
      bus.m_ready = 1'b0;
      do_reset();
      load(8'h10, 8);
      repeat (3) @(posedge clk);
      #1;
      check("pre_rst_valid", 32'(bus.m_valid), 32'd1);
      check("pre_rst_idle", 32'(bus.idle), 32'd0);
      rst = 1'b1;
      ftail = fhead;
      @(posedge clk);
      #1 rst = 1'b0;
      clear_logs();
      @(negedge clk);
      check("mid_rst_valid", 32'(bus.m_valid), 32'd0);
      check("mid_rst_idle",  32'(bus.idle),    32'd1);
      @(posedge clk);
      #1 bus.m_ready = 1'b1;
      load(8'hA0, 4);
      wait_beats(4, 30, "refill_timeout");
      check_seq("refill", 8'hA0, 4);
      repeat (3) @(posedge clk);
      check("refill_count", 32'(log_d.size()), 32'd4);

      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
